// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_if
//  Purpose  : Request/response bundle between the core and lsu_unit.
//             master = requester, slave = load/store unit.
//  Revision : 1.0  initial release
// ============================================================================
interface lsu_if #(
  parameter int XLEN = 64
);
  logic            start;
  logic            op_load;
  logic [1:0]      size;
  logic            sign_ext;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] offset;
  logic            busy;
  logic            done;
  logic            misaligned;
  logic            out_of_range;
  logic [XLEN-1:0] addr_out;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] store_data;

  modport master (
    output start, op_load, size, sign_ext, rs1, rs2, rd, offset,
    input  busy, done, misaligned, out_of_range, addr_out, load_data, store_data
  );

  modport slave (
    input  start, op_load, size, sign_ext, rs1, rs2, rd, offset,
    output busy, done, misaligned, out_of_range, addr_out, load_data, store_data
  );
endinterface
`default_nettype wire

// File: rtl/lsu_unit.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_unit
//  Purpose  : Multi-cycle load/store unit with private register file and
//             word-organised little-endian data memory.
//             IDLE -> ADDR -> MEM -> WB -> IDLE, start/done handshake,
//             byte/half/word/double accesses, alignment and range faults.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_unit #(
  parameter int XLEN        = 64,
  parameter int MEM_DEPTH   = 1024,
  parameter int REG_COUNT   = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);

  localparam int MIDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W  = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_MEM  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  // Control state and latched request
  state_t          state_q;
  logic            op_load_q;
  logic [1:0]      size_q;
  logic            sign_ext_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] offset_q;
  logic [CNT_W-1:0] cnt_q;

  // Storage; mem is deliberately left without a reset
  logic [XLEN-1:0] rf_q [REG_COUNT];
  logic [XLEN-1:0] mem  [MEM_DEPTH];

  // Registered outputs
  logic            done_q;
  logic            mis_q;
  logic            oor_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] load_q;
  logic [XLEN-1:0] store_q;

  // Next-state / datapath values
  logic [XLEN-1:0] addr_d;
  logic            mis_d;
  logic            oor_d;
  logic [5:0]      shamt_d;
  logic [MIDX_W-1:0] widx_d;
  logic [XLEN-1:0] word_d;
  logic [XLEN-1:0] mask_d;
  logic [XLEN-1:0] wdata_d;
  logic [XLEN-1:0] merged_d;
  logic [XLEN-1:0] raw_d;
  logic [XLEN-1:0] load_d;
  logic            mem_we_d;

  // Address generation, fault detection, lane merge and load extraction
  always_comb begin
    addr_d = rf_q[rs1_q] + offset_q;

    mis_d = 1'b0;
    case (size_q)
      2'b00:   mis_d = 1'b0;
      2'b01:   mis_d = addr_d[0];
      2'b10:   mis_d = |addr_d[1:0];
      default: mis_d = |addr_d[2:0];
    endcase

    // Word index is addr >> 3; compare the full shifted value so huge
    // addresses never alias back into range.
    oor_d = (addr_d >> 3) >= XLEN'(MEM_DEPTH);

    // WB works off the address registered in ADDR
    shamt_d = {addr_q[2:0], 3'b000};
    widx_d  = addr_q[3 +: MIDX_W];
    word_d  = mem[widx_d];

    mask_d = '1;
    case (size_q)
      2'b00:   mask_d = XLEN'(8'hFF)         << shamt_d;
      2'b01:   mask_d = XLEN'(16'hFFFF)      << shamt_d;
      2'b10:   mask_d = XLEN'(32'hFFFF_FFFF) << shamt_d;
      default: mask_d = '1;
    endcase

    wdata_d  = rf_q[rs2_q] << shamt_d;
    merged_d = (word_d & ~mask_d) | (wdata_d & mask_d);

    raw_d  = word_d >> shamt_d;
    load_d = raw_d;
    case (size_q)
      2'b00:   load_d = sign_ext_q ? {{(XLEN-8){raw_d[7]}},   raw_d[7:0]}
                                   : {{(XLEN-8){1'b0}},       raw_d[7:0]};
      2'b01:   load_d = sign_ext_q ? {{(XLEN-16){raw_d[15]}}, raw_d[15:0]}
                                   : {{(XLEN-16){1'b0}},      raw_d[15:0]};
      2'b10:   load_d = sign_ext_q ? {{(XLEN-32){raw_d[31]}}, raw_d[31:0]}
                                   : {{(XLEN-32){1'b0}},      raw_d[31:0]};
      default: load_d = raw_d;
    endcase

    // rst in the WB cycle aborts the write
    mem_we_d = (state_q == S_WB) && !op_load_q && !rst;
  end

  // Data memory write port (store WB only)
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem[widx_d] <= merged_d;
    end
  end

  // Main FSM: request latch, address phase, latency wait, writeback
  always_ff @(posedge clk) begin
    done_q <= 1'b0;
    if (rst) begin
      state_q    <= S_IDLE;
      op_load_q  <= 1'b0;
      size_q     <= 2'b00;
      sign_ext_q <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      offset_q   <= '0;
      cnt_q      <= '0;
      mis_q      <= 1'b0;
      oor_q      <= 1'b0;
      addr_q     <= '0;
      load_q     <= '0;
      store_q    <= '0;
      for (int i = 0; i < REG_COUNT; i++) begin
        rf_q[i] <= XLEN'(i);
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_load_q  <= bus.op_load;
            size_q     <= bus.size;
            sign_ext_q <= bus.sign_ext;
            rs1_q      <= bus.rs1;
            rs2_q      <= bus.rs2;
            rd_q       <= bus.rd;
            offset_q   <= bus.offset;
            state_q    <= S_ADDR;
          end
        end
        S_ADDR: begin
          addr_q <= addr_d;
          if (mis_d || oor_d) begin
            mis_q   <= mis_d;
            oor_q   <= oor_d;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q   <= CNT_W'(MEM_LATENCY);
            state_q <= S_MEM;
          end
        end
        S_MEM: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= S_WB;
          end
        end
        S_WB: begin
          if (op_load_q) begin
            if (rd_q != 5'd0) begin
              rf_q[rd_q] <= load_d;
            end
            load_q <= load_d;
          end else begin
            store_q <= merged_d;
          end
          mis_q   <= 1'b0;
          oor_q   <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = done_q;
  assign bus.misaligned   = mis_q;
  assign bus.out_of_range = oor_q;
  assign bus.addr_out     = addr_q;
  assign bus.load_data    = load_q;
  assign bus.store_data   = store_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_unit
//  Purpose  : Directed vector table plus hand sequences for lsu_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_unit;

  localparam int XLEN      = 64;
  localparam int MEM_DEPTH = 1024;
  localparam int NVEC      = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if #(.XLEN(XLEN)) bus ();

  lsu_unit #(
    .XLEN        (XLEN),
    .MEM_DEPTH   (MEM_DEPTH),
    .REG_COUNT   (32),
    .MEM_LATENCY (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        ld;
    logic [1:0]  sz;
    logic        sx;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] off;
    int          lat;
    logic        mis;
    logic        oor;
    logic [63:0] addr;
    logic [63:0] data;  // load_data for loads, store_data for stores
    int          kind;  // 1 = check register idx, 2 = check mem word idx
    int          idx;
    logic [63:0] val;
  } vec_t;

  vec_t vecs [NVEC];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
  endtask

  task automatic set_req(input vec_t v);
    bus.op_load  = v.ld;
    bus.size     = v.sz;
    bus.sign_ext = v.sx;
    bus.rs1      = v.rs1;
    bus.rs2      = v.rs2;
    bus.rd       = v.rd;
    bus.offset   = v.off;
  endtask

  // Present a request for exactly one sampling edge, return #1 after it
  task automatic launch(input vec_t v);
    @(negedge clk);
    set_req(v);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count edges until done is seen; bounded
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 40 && bus.done !== 1'b1) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   lat;
    vec_t va, vb;

    // Store double, load back, byte loads, byte store
    vecs[0]  = '{1'b0, 2'd3, 1'b0, 5'd0, 5'd5,  5'd0,  64'd16,  4, 1'b0, 1'b0, 64'h10,   64'h5,                  2, 2,  64'h5};
    vecs[1]  = '{1'b1, 2'd3, 1'b1, 5'd0, 5'd0,  5'd7,  64'd16,  4, 1'b0, 1'b0, 64'h10,   64'h5,                  1, 7,  64'h5};
    vecs[2]  = '{1'b1, 2'd0, 1'b1, 5'd0, 5'd0,  5'd3,  64'd9,   4, 1'b0, 1'b0, 64'h9,    64'hFFFF_FFFF_FFFF_FF80, 1, 3,  64'hFFFF_FFFF_FFFF_FF80};
    vecs[3]  = '{1'b1, 2'd0, 1'b0, 5'd0, 5'd0,  5'd3,  64'd9,   4, 1'b0, 1'b0, 64'h9,    64'h80,                 1, 3,  64'h80};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 5'd0, 5'd31, 5'd0,  64'h13,  4, 1'b0, 1'b0, 64'h13,   64'h1F00_0005,          2, 2,  64'h1F00_0005};
    // Half / word loads, base register plus offset
    vecs[5]  = '{1'b1, 2'd1, 1'b1, 5'd0, 5'd0,  5'd4,  64'd8,   4, 1'b0, 1'b0, 64'h8,    64'hFFFF_FFFF_FFFF_80FE, 1, 4,  64'hFFFF_FFFF_FFFF_80FE};
    vecs[6]  = '{1'b1, 2'd2, 1'b1, 5'd0, 5'd0,  5'd6,  64'h10,  4, 1'b0, 1'b0, 64'h10,   64'h1F00_0005,          1, 6,  64'h1F00_0005};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 5'd8, 5'd0,  5'd9,  64'hA,   4, 1'b0, 1'b0, 64'h12,   64'h1F00,               1, 9,  64'h1F00};
    // Faults: misaligned, out of range, both
    vecs[8]  = '{1'b1, 2'd1, 1'b1, 5'd0, 5'd0,  5'd10, 64'd3,   1, 1'b1, 1'b0, 64'h3,    64'h1F00,               1, 10, 64'd10};
    vecs[9]  = '{1'b1, 2'd3, 1'b0, 5'd0, 5'd0,  5'd11, 64'd8192,1, 1'b0, 1'b1, 64'h2000, 64'h1F00,               1, 11, 64'd11};
    vecs[10] = '{1'b1, 2'd1, 1'b0, 5'd0, 5'd0,  5'd13, 64'd8193,1, 1'b1, 1'b1, 64'h2001, 64'h1F00,               1, 13, 64'd13};
    // Load to R0 is discarded
    vecs[11] = '{1'b1, 2'd3, 1'b0, 5'd0, 5'd0,  5'd0,  64'd16,  4, 1'b0, 1'b0, 64'h10,   64'h1F00_0005,          1, 0,  64'h0};
    // Misaligned store leaves memory alone
    vecs[12] = '{1'b0, 2'd2, 1'b0, 5'd0, 5'd31, 5'd0,  64'h12,  1, 1'b1, 1'b0, 64'h12,   64'h1F00_0005,          2, 2,  64'h1F00_0005};
    // Negative offset
    vecs[13] = '{1'b1, 2'd3, 1'b1, 5'd31,5'd0,  5'd12, 64'hFFFF_FFFF_FFFF_FFF1, 4, 1'b0, 1'b0, 64'h10, 64'h1F00_0005, 1, 12, 64'h1F00_0005};
    // Half store from a register written by an earlier load
    vecs[14] = '{1'b0, 2'd1, 1'b0, 5'd0, 5'd7,  5'd0,  64'h16,  4, 1'b0, 1'b0, 64'h16,   64'h0005_0000_1F00_0005, 2, 2, 64'h0005_0000_1F00_0005};

    bus.start    = 1'b0;
    bus.op_load  = 1'b0;
    bus.size     = 2'b00;
    bus.sign_ext = 1'b0;
    bus.rs1      = '0;
    bus.rs2      = '0;
    bus.rd       = '0;
    bus.offset   = '0;

    for (int i = 0; i < MEM_DEPTH; i++) dut.mem[i] = 64'(i);
    dut.mem[1] = 64'h80FE;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy",         64'(bus.busy),         64'd0);
    chk("reset done",         64'(bus.done),         64'd0);
    chk("reset misaligned",   64'(bus.misaligned),   64'd0);
    chk("reset out_of_range", 64'(bus.out_of_range), 64'd0);
    chk("reset addr_out",     bus.addr_out,          64'd0);
    chk("reset load_data",    bus.load_data,         64'd0);
    chk("reset store_data",   bus.store_data,        64'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("reset R%0d", i), dut.rf_q[i], 64'(i));
    @(negedge clk);
    rst = 1'b0;

    // Vector table
    for (int k = 0; k < NVEC; k++) begin
      launch(vecs[k]);
      wait_done(lat);
      chk($sformatf("v%0d latency", k),      64'(lat),              64'(vecs[k].lat));
      chk($sformatf("v%0d busy@done", k),    64'(bus.busy),         64'd0);
      chk($sformatf("v%0d misaligned", k),   64'(bus.misaligned),   64'(vecs[k].mis));
      chk($sformatf("v%0d out_of_range", k), 64'(bus.out_of_range), 64'(vecs[k].oor));
      chk($sformatf("v%0d addr_out", k),     bus.addr_out,          vecs[k].addr);
      if (vecs[k].ld) chk($sformatf("v%0d load_data", k),  bus.load_data,  vecs[k].data);
      else            chk($sformatf("v%0d store_data", k), bus.store_data, vecs[k].data);
      if (vecs[k].kind == 1) chk($sformatf("v%0d R%0d", k, vecs[k].idx),   dut.rf_q[vecs[k].idx], vecs[k].val);
      else                   chk($sformatf("v%0d mem%0d", k, vecs[k].idx), dut.mem[vecs[k].idx],  vecs[k].val);
    end

    // Back-to-back: start held high through busy and into the done cycle
    va = '{1'b1, 2'd3, 1'b0, 5'd0, 5'd0, 5'd15, 64'd16, 4, 1'b0, 1'b0, 64'h10, 64'h0, 1, 15, 64'h0};
    vb = '{1'b1, 2'd0, 1'b0, 5'd0, 5'd0, 5'd16, 64'd9,  4, 1'b0, 1'b0, 64'h9,  64'h0, 1, 16, 64'h0};
    @(negedge clk);
    set_req(va);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(lat);
    chk("b2b first latency", 64'(lat), 64'd4);
    chk("b2b first R15", dut.rf_q[15], 64'h0005_0000_1F00_0005);
    set_req(vb);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b second accepted busy", 64'(bus.busy), 64'd1);
    wait_done(lat);
    chk("b2b second latency", 64'(lat), 64'd4);
    chk("b2b second R16", dut.rf_q[16], 64'h80);
    chk("b2b second load_data", bus.load_data, 64'h80);
    @(posedge clk);
    #1;
    chk("b2b done one cycle", 64'(bus.done), 64'd0);
    chk("b2b no extra op", 64'(bus.busy), 64'd0);

    // Reset in the middle of a store
    va = '{1'b0, 2'd3, 1'b0, 5'd0, 5'd3, 5'd0, 64'd16, 4, 1'b0, 1'b0, 64'h10, 64'h0, 2, 2, 64'h0};
    launch(va);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst busy",       64'(bus.busy), 64'd0);
    chk("rst done",       64'(bus.done), 64'd0);
    chk("rst mem2",       dut.mem[2],    64'h0005_0000_1F00_0005);
    chk("rst mem1",       dut.mem[1],    64'h80FE);
    chk("rst R3",         dut.rf_q[3],   64'd3);
    chk("rst R15",        dut.rf_q[15],  64'd15);
    chk("rst load_data",  bus.load_data, 64'd0);
    chk("rst store_data", bus.store_data,64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post rst idle done", 64'(bus.done), 64'd0);
    chk("post rst mem2",      dut.mem[2],    64'h0005_0000_1F00_0005);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_unit.md
# lsu_unit

Parametrised load/store execution unit for the 64-bit datapath: it owns a REG_COUNT-entry register file and a word-organised data memory. It computes `addr = R[rs1] + offset` and runs a multi-cycle FSM with a start/done handshake. It supports loads and stores of byte, half, word and double size, with sign/zero extension and alignment/range faults. It replaces the single-cycle, store-only unit as the memory stage of the core.

## Interface
- XLEN, 64, data/address width; must be 64 (8 byte lanes).
- MEM_DEPTH, 1024, number of XLEN-bit memory words.
- REG_COUNT, 32, register-file entries; index width 5.
- MEM_LATENCY, 2, wait cycles spent in MEM state; must be ≥ 1.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op_load  in  1  1 = load, 0 = store.
- size  in  2  00 byte, 01 half, 10 word, 11 double.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- rs1  in  5  base register.
- rs2  in  5  store-data register.
- rd  in  5  load destination register.
- offset  in  XLEN  signed byte offset.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse (success or fault).
- misaligned  out  1  valid with done: address not a multiple of 2^size.
- out_of_range  out  1  valid with done: addr[XLEN-1:3] ≥ MEM_DEPTH.
- addr_out  out  XLEN  effective byte address of the current/last op.
- load_data  out  XLEN  extended load result; holds until the next load completes.
- store_data  out  XLEN  merged memory word written by the last store.

## Operation
- Reset (rst=1 at an edge): state IDLE; R[i] = i for all i; busy, done, misaligned, out_of_range = 0; addr_out, load_data, store_data = 0. Memory (`mem`) has no reset. Initial contents: word i = i. The bench may preload `mem` hierarchically.
- R[0] reads 0 always; writes to R[0] are discarded.
- Memory is little-endian. The byte address selects word addr[XLEN-1:3] and lane addr[2:0].
- FSM: IDLE → ADDR → MEM → WB → IDLE.
  - IDLE: when start=1, latch op_load, size, sign_ext, rs1, rs2, rd and offset, then go to ADDR. With start=0, stay.
  - ADDR: compute addr = R[rs1] + offset (mod 2^XLEN) and register it into addr_out.
    - If misaligned or out of range, go to IDLE with done=1 and the matching flag(s) set. There is no memory or register write.
    - Otherwise load the wait counter and go to MEM.
  - MEM: count MEM_LATENCY cycles, then go to WB.
  - WB, store: merge the low 8·2^size bits of R[rs2] into the addressed lanes; other lanes are unchanged. Write the word to mem and to store_data.
  - WB, load: extract the lanes and extend them per sign_ext. A double load ignores sign_ext. Write the result to R[rd] (unless rd=0) and to load_data.
  - WB then goes to IDLE with done=1 and both flags = 0.
- misaligned and out_of_range hold their value until the next done. Both may be set together.
- start while busy is ignored. There is no queueing.

## Timing
- Let edge N be the edge that samples start.
  - ADDR is evaluated at edge N+1.
  - MEM is entered at edge N+1 and occupies edges N+2 … N+1+MEM_LATENCY.
  - WB writes at edge N+2+MEM_LATENCY; done is high in the following cycle.
  - With MEM_LATENCY=2, done is high in the cycle after edge N+4.
- Fault: done is high in the cycle after edge N+1.
- busy is high from the cycle after edge N until done; it is low in the same cycle as the done pulse.
- Back-to-back: start may be held high in the done cycle and is accepted at that edge.
- A register written in WB is visible to the next operation's ADDR.
- rst mid-operation aborts at that edge. No memory or register write happens at that edge and done stays 0. R is reinitialised and mem is untouched.

## Test plan
- Store double: rs1=0, offset=16, rs2=5, size=11 → done after edge N+4 (latency 2); mem[2]=5; store_data=5; flags 0.
- Load back: load, rs1=0, offset=16, size=11, rd=7 → R[7]=5; load_data=5.
- Preload mem[1]=0x0000_0000_0000_80FE. Load byte, offset=9, sign_ext=1, rd=3 → R[3]=0xFFFF_FFFF_FFFF_FF80. Same with sign_ext=0 → 0x80.
- Store byte: R[31]=31, offset=0x13 (word 2, lane 3), rs2=31 onto mem[2]=5 → mem[2]=0x0000_0000_1F00_0005.
- Faults:
  - Half access at offset=3 → done after edge N+1 with misaligned=1; memory and registers unchanged.
  - Offset = 8·MEM_DEPTH → out_of_range=1.
  - Load to rd=0 → R[0] still reads 0.
- Assert rst at edge N+2 of a store → mem unchanged, done=0, busy=0, R[i]=i; a start held high during busy is ignored.
